line_window_7row: RTL and testbench

Raster-to-column window generator feeding the 7x7 median filter. Accepts one pixel per cycle in raster order and produces, per accepted pixel, the 7 vertically aligned pixels of that column: the current row plus the 6 rows above it. The outputs map directly onto the filter's `in0..in6` inputs, and the block drives the filter's `refresh` strobe at frame start. Line storage is 6 row buffers of `IMG_WIDTH` entries each.

---
 rtl/line_window_7row.sv | 181 ++++++++++++++++++
 tb/tb_line_window_7row.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/line_window_7row.sv
// line_window_7row
// Turns a raster pixel stream into 7-pixel vertical column windows for the
// 7x7 median filter. Six row buffers hold the previous six lines. Rows that
// have not yet been written in the current frame are masked to zero.
// Pipeline: buffer read stage, masking stage, output stage.
// A pixel accepted at edge N reaches the outputs after edge N+2.
module line_window_7row #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 640,
  parameter int COL_BITS   = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic                  in_sof,
  input  logic [DATA_WIDTH-1:0] in_pixel,
  output logic [DATA_WIDTH-1:0] out0,
  output logic [DATA_WIDTH-1:0] out1,
  output logic [DATA_WIDTH-1:0] out2,
  output logic [DATA_WIDTH-1:0] out3,
  output logic [DATA_WIDTH-1:0] out4,
  output logic [DATA_WIDTH-1:0] out5,
  output logic [DATA_WIDTH-1:0] out6,
  output logic                  out_valid,
  output logic                  refresh
);

  localparam logic [COL_BITS-1:0] LAST_COL = COL_BITS'(IMG_WIDTH - 1);
  localparam logic [2:0]          FULL_ROWS = 3'd6;

  // Position tracking within the frame
  logic [COL_BITS-1:0]   r_col;
  logic [2:0]            r_rows;
  logic [COL_BITS-1:0]   w_col;
  logic [2:0]            w_rows;

  // Row buffers: index 0 holds the previous row, index 5 the oldest
  logic [DATA_WIDTH-1:0] r_buf [6][IMG_WIDTH];
  logic [DATA_WIDTH-1:0] r_rd  [6];

  // Read stage registers
  logic                  r_p0_acc;
  logic                  r_p0_sof;
  logic [2:0]            r_p0_rows;
  logic [DATA_WIDTH-1:0] r_p0_pixel;

  // Masking stage
  logic [DATA_WIDTH-1:0] w_win [7];
  logic                  r_s1_acc;
  logic                  r_s1_valid;
  logic                  r_sof_d;
  logic [DATA_WIDTH-1:0] r_s1_win [7];

  // Output stage
  logic [DATA_WIDTH-1:0] r_out [7];
  logic                  r_out_valid;

  // A start-of-frame pixel is always handled as row 0, column 0
  always_comb begin
    w_col  = r_col;
    w_rows = r_rows;
    if (in_sof) begin
      w_col  = '0;
      w_rows = '0;
    end
  end

  // Column and completed-row counters; sof restarts the frame at column 1 after the sof pixel
  always_ff @(posedge clk) begin
    if (rst) begin
      r_col  <= '0;
      r_rows <= '0;
    end else if (in_valid) begin
      if (in_sof) begin
        r_col  <= COL_BITS'(1);
        r_rows <= '0;
      end else if (r_col == LAST_COL) begin
        r_col <= '0;
        if (r_rows != FULL_ROWS) begin
          r_rows <= r_rows + 3'd1;
        end
      end else begin
        r_col <= r_col + COL_BITS'(1);
      end
    end
  end

  // Read-before-write on each buffer at the current column, shifting the column down one row
  always_ff @(posedge clk) begin
    if (in_valid && !rst) begin
      for (int k = 0; k < 6; k++) begin
        r_rd[k] <= r_buf[k][w_col];
        if (k == 0) begin
          r_buf[0][w_col] <= in_pixel;
        end else begin
          r_buf[k][w_col] <= r_buf[k-1][w_col];
        end
      end
    end
  end

  // Carry the pixel and its frame context alongside the buffer read
  always_ff @(posedge clk) begin
    if (rst) begin
      r_p0_acc   <= 1'b0;
      r_p0_sof   <= 1'b0;
      r_p0_rows  <= '0;
      r_p0_pixel <= '0;
    end else begin
      r_p0_acc <= in_valid;
      r_p0_sof <= in_valid && in_sof;
      if (in_valid) begin
        r_p0_rows  <= w_rows;
        r_p0_pixel <= in_pixel;
      end
    end
  end

  // Build the window, zeroing rows older than what this frame has written
  always_comb begin
    for (int k = 0; k < 7; k++) begin
      w_win[k] = '0;
    end
    w_win[6] = r_p0_pixel;
    for (int k = 0; k < 6; k++) begin
      if (3'(k) < r_p0_rows) begin
        w_win[5-k] = r_rd[k];
      end
    end
  end

  // Register the masked window, its validity and the frame-start marker
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_acc   <= 1'b0;
      r_s1_valid <= 1'b0;
      r_sof_d    <= 1'b0;
      for (int k = 0; k < 7; k++) begin
        r_s1_win[k] <= '0;
      end
    end else begin
      r_s1_acc   <= r_p0_acc;
      r_s1_valid <= r_p0_acc && (r_p0_rows == FULL_ROWS);
      r_sof_d    <= r_p0_acc && r_p0_sof;
      if (r_p0_acc) begin
        for (int k = 0; k < 7; k++) begin
          r_s1_win[k] <= w_win[k];
        end
      end
    end
  end

  // Present the window; pixel data holds across idle cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      for (int k = 0; k < 7; k++) begin
        r_out[k] <= '0;
      end
    end else begin
      r_out_valid <= r_s1_valid;
      if (r_s1_acc) begin
        for (int k = 0; k < 7; k++) begin
          r_out[k] <= r_s1_win[k];
        end
      end
    end
  end

  assign out0      = r_out[0];
  assign out1      = r_out[1];
  assign out2      = r_out[2];
  assign out3      = r_out[3];
  assign out4      = r_out[4];
  assign out5      = r_out[5];
  assign out6      = r_out[6];
  assign out_valid = r_out_valid;
  // The filter clears its queue one cycle before the first window arrives
  assign refresh   = r_sof_d;

endmodule

// File: tb/tb_line_window_7row.sv
// tb_line_window_7row
// Directed stimulus for the 7-row column window generator with an
// image-based reference model and a few literal pins.
module tb_line_window_7row;

  localparam int W = 8;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_sof;
  logic [7:0] in_pixel;
  logic [7:0] out0, out1, out2, out3, out4, out5, out6;
  logic       out_valid;
  logic       refresh;

  int checks = 0;
  int errors = 0;

  line_window_7row #(.DATA_WIDTH(8), .IMG_WIDTH(W), .COL_BITS(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof),
    .in_pixel(in_pixel),
    .out0(out0), .out1(out1), .out2(out2), .out3(out3),
    .out4(out4), .out5(out5), .out6(out6),
    .out_valid(out_valid), .refresh(refresh)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic            acc;
    logic            sof;
    logic            vld;
    logic [7:0]      pix;
    logic [6:0][7:0] win;
  } ent_t;

  // Reference model: the frame as an image indexed by logical row/column
  logic [7:0]      img [64][W];
  int              mr = 0;
  int              mc = 0;
  ent_t            e, h0, h1, h2;
  logic [6:0][7:0] expOut;
  logic            expValid, expRefresh;
  logic            checkOn = 1'b0;
  logic            litOn = 1'b0;
  logic            midOn = 1'b0;
  logic [55:0]     dutWin;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update at each edge, then comparison 1 time unit later
  always @(posedge clk) begin
    e = '0;
    if (rst) begin
      mr = 0; mc = 0;
      h0 = '0; h1 = '0; h2 = '0;
      expOut = '0;
      checkOn = 1'b1;
    end else begin
      if (in_valid) begin
        if (in_sof) begin
          mr = 0; mc = 0;
        end
        e.acc = 1'b1;
        e.sof = in_sof;
        e.pix = in_pixel;
        e.vld = (mr >= 6);
        e.win[6] = in_pixel;
        for (int j = 1; j <= 6; j++) begin
          e.win[6-j] = (j <= mr) ? img[(mr - j) % 64][mc] : 8'h00;
        end
        img[mr % 64][mc] = in_pixel;
        mc++;
        if (mc == W) begin
          mc = 0;
          mr++;
        end
      end
      h2 = h1; h1 = h0; h0 = e;
      if (h2.acc) expOut = h2.win;
    end
    expValid   = h2.acc && h2.vld;
    expRefresh = h1.acc && h1.sof;
    #1;
    if (checkOn) begin
      dutWin = {out6, out5, out4, out3, out2, out1, out0};
      checkOutput("window", 64'(dutWin), 64'(expOut));
      checkOutput("out_valid", 64'(out_valid), 64'(expValid));
      checkOutput("refresh", 64'(refresh), 64'(expRefresh));
      if (litOn && h2.acc && !h2.sof && h2.pix == 8'h23) begin
        checkOutput("pin_r2c3_upper", 64'({out6, out5, out4}), 64'(24'h231303));
        checkOutput("pin_r2c3_lower", 64'({out3, out2, out1, out0}), 64'd0);
        checkOutput("pin_r2c3_valid", 64'(out_valid), 64'd0);
      end
      if (litOn && h2.acc && h2.pix == 8'h75) begin
        checkOutput("pin_r7c5_win", 64'(dutWin), 64'(56'h75655545352515));
        checkOutput("pin_r7c5_valid", 64'(out_valid), 64'd1);
      end
      if (midOn && h2.acc && h2.sof && h2.pix == 8'h84) begin
        checkOutput("pin_midsof_win", 64'(dutWin), 64'(56'h84000000000000));
        checkOutput("pin_midsof_valid", 64'(out_valid), 64'd0);
      end
    end
  end

  task automatic applyStimulus(input logic v, input logic s, input logic [7:0] p);
    @(negedge clk);
    in_valid = v;
    in_sof   = s;
    in_pixel = p;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
  endtask

  task automatic sendFrame(input int nRows, input int nCols, input bit gaps,
                           input bit sofFirst, input int sofRow, input int sofCol,
                           input int base);
    for (int r = 0; r < nRows; r++) begin
      for (int c = 0; c < nCols; c++) begin
        if (gaps) applyStimulus(1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
        applyStimulus(1'b1,
                      (sofFirst && r == 0 && c == 0) || (r == sofRow && c == sofCol),
                      8'((r * 16 + c + base) % 256));
      end
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_pixel = 8'h00;
    // Reset with random inputs
    for (int i = 0; i < 3; i++) applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
    @(negedge clk);
    checkOutput("reset_window", 64'({out6, out5, out4, out3, out2, out1, out0}), 64'd0);
    checkOutput("reset_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_refresh", 64'(refresh), 64'd0);
    rst = 1'b0; in_valid = 1'b0; in_sof = 1'b0;
    idle(2);

    // Full-rate frame, then the same frame with gaps
    litOn = 1'b1;
    sendFrame(10, W, 1'b0, 1'b1, -1, -1, 0);
    idle(4);
    sendFrame(10, W, 1'b1, 1'b1, -1, -1, 0);
    idle(4);
    litOn = 1'b0;

    // Mid-frame restart at row 8 col 4
    midOn = 1'b1;
    sendFrame(16, W, 1'b0, 1'b1, 8, 4, 0);
    idle(4);
    midOn = 1'b0;

    // Back-to-back frames
    sendFrame(10, W, 1'b0, 1'b1, -1, -1, 8'h40);
    sendFrame(8, W, 1'b0, 1'b1, -1, -1, 1);
    idle(3);

    // Reset mid-frame at row 7, then rows without sof
    sendFrame(7, W, 1'b0, 1'b1, -1, -1, 8'h20);
    sendFrame(1, 3, 1'b0, 1'b0, -1, -1, 8'h90);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    sendFrame(8, W, 1'b0, 1'b0, -1, -1, 8'h05);
    idle(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
